// File: rtl/readout_pkg.sv
// Shared types and widths for the qubit readout sequencer.
package readout_pkg;

    localparam int SHOT_W       = 8;
    localparam int LEN_W        = 11;
    localparam int DLY_W        = 8;
    localparam int IQ_W_DEFAULT = 35;
    localparam int TMR_W        = LEN_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        START,
        WAIT,
        RESULT,
        DONE
    } state_t;

    // Timer expires when its count reaches zero, so loads are length-1.
    function automatic logic [TMR_W-1:0] delay_load(input logic [DLY_W-1:0] d);
        return (d == '0) ? '0 : TMR_W'(d - 1'b1);
    endfunction

    function automatic logic [TMR_W-1:0] wait_load(
        input logic [LEN_W-1:0] len,
        input int               margin
    );
        logic [TMR_W-1:0] total;
        total = TMR_W'(len) + TMR_W'(margin);
        return (total == '0) ? '0 : total - 1'b1;
    endfunction

endpackage

// File: rtl/readout_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module readout_timer
    import readout_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk100,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/readout_sequencer.sv
// Shot sequencer: delay, fire integrator, collect I/Q, discriminate, hand off.
module readout_sequencer
    import readout_pkg::*;
#(
    parameter int IQ_W      = IQ_W_DEFAULT,
    parameter int TO_MARGIN = 16
) (
    input  logic              clk100,
    input  logic              reset,
    input  logic              cmd_start,
    input  logic              cmd_abort,
    input  logic [SHOT_W-1:0] cfg_num_shots,
    input  logic [DLY_W-1:0]  cfg_delay,
    input  logic [LEN_W-1:0]  cfg_sample_length,
    input  logic [IQ_W-1:0]   cfg_threshold,
    output logic              int_start,
    output logic [LEN_W-1:0]  int_sample_length,
    input  logic              int_iq_valid,
    input  logic [IQ_W-1:0]   int_i_val_tot,
    input  logic [IQ_W-1:0]   int_q_val_tot,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IQ_W-1:0]   res_i,
    output logic [IQ_W-1:0]   res_q,
    output logic [SHOT_W-1:0] res_idx,
    output logic              res_excited,
    output logic [SHOT_W-1:0] excited_count,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_t            state;
    logic [SHOT_W-1:0] num_q;
    logic [DLY_W-1:0]  delay_q;
    logic [IQ_W-1:0]   thr_q;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_value;
    logic              tmr_expired;

    // One timer: loaded on the way into DELAY and again in START for WAIT.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = '0;
        unique case (state)
            IDLE: begin
                tmr_load  = cmd_start;
                tmr_value = delay_load(cfg_delay);
            end
            RESULT: begin
                tmr_load  = res_ready;
                tmr_value = delay_load(delay_q);
            end
            START: begin
                tmr_load  = 1'b1;
                tmr_value = wait_load(int_sample_length, TO_MARGIN);
            end
            default: ;
        endcase
    end

    readout_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk100 (clk100),
        .reset  (reset),
        .load   (tmr_load),
        .value  (tmr_value),
        .expired(tmr_expired)
    );

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            num_q             <= '0;
            delay_q           <= '0;
            thr_q             <= '0;
            int_start         <= 1'b0;
            int_sample_length <= '0;
            res_valid         <= 1'b0;
            res_i             <= '0;
            res_q             <= '0;
            res_idx           <= '0;
            res_excited       <= 1'b0;
            excited_count     <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            error             <= 1'b0;
        end else begin
            int_start <= 1'b0;
            done      <= 1'b0;
            if (cmd_abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                res_valid <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (cmd_start) begin
                            num_q             <= cfg_num_shots;
                            delay_q           <= cfg_delay;
                            thr_q             <= cfg_threshold;
                            int_sample_length <= cfg_sample_length;
                            res_idx           <= '0;
                            excited_count     <= '0;
                            error             <= 1'b0;
                            busy              <= 1'b1;
                            if (cfg_num_shots == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= DELAY;
                            end
                        end
                    end
                    DELAY: begin
                        if (tmr_expired) begin
                            state     <= START;
                            int_start <= 1'b1;
                        end
                    end
                    START: begin
                        state <= WAIT;
                    end
                    WAIT: begin
                        if (int_iq_valid) begin
                            res_i       <= int_i_val_tot;
                            res_q       <= int_q_val_tot;
                            res_excited <= $signed(int_i_val_tot) > $signed(thr_q);
                            res_valid   <= 1'b1;
                            state       <= RESULT;
                        end else if (tmr_expired) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    RESULT: begin
                        if (res_ready) begin
                            res_valid <= 1'b0;
                            if (res_excited && excited_count != '1) begin
                                excited_count <= excited_count + 1'b1;
                            end
                            if (res_idx == num_q - 1'b1) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                res_idx <= res_idx + 1'b1;
                                state   <= DELAY;
                            end
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer with a fixed-latency integrator model.
module tb_readout_sequencer;

    localparam int IQ_W = 35;

    logic            clk100 = 1'b0;
    logic            reset;
    logic            cmd_start;
    logic            cmd_abort;
    logic [7:0]      cfg_num_shots;
    logic [7:0]      cfg_delay;
    logic [10:0]     cfg_sample_length;
    logic [IQ_W-1:0] cfg_threshold;
    logic            int_start;
    logic [10:0]     int_sample_length;
    logic            int_iq_valid;
    logic [IQ_W-1:0] int_i_val_tot;
    logic [IQ_W-1:0] int_q_val_tot;
    logic            res_valid;
    logic            res_ready;
    logic [IQ_W-1:0] res_i;
    logic [IQ_W-1:0] res_q;
    logic [7:0]      res_idx;
    logic            res_excited;
    logic [7:0]      excited_count;
    logic            busy;
    logic            done;
    logic            error;

    int checks = 0;
    int passes = 0;

    logic signed [IQ_W-1:0] i_tab [4];
    logic signed [IQ_W-1:0] q_tab [4];
    logic                   model_en;
    logic                   man_valid;
    logic                   mvalid;
    logic [3:0]             mcnt;

    always #5 clk100 = ~clk100;

    readout_sequencer #(
        .IQ_W     (IQ_W),
        .TO_MARGIN(16)
    ) dut (
        .clk100           (clk100),
        .reset            (reset),
        .cmd_start        (cmd_start),
        .cmd_abort        (cmd_abort),
        .cfg_num_shots    (cfg_num_shots),
        .cfg_delay        (cfg_delay),
        .cfg_sample_length(cfg_sample_length),
        .cfg_threshold    (cfg_threshold),
        .int_start        (int_start),
        .int_sample_length(int_sample_length),
        .int_iq_valid     (int_iq_valid),
        .int_i_val_tot    (int_i_val_tot),
        .int_q_val_tot    (int_q_val_tot),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_i            (res_i),
        .res_q            (res_q),
        .res_idx          (res_idx),
        .res_excited      (res_excited),
        .excited_count    (excited_count),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    // Integrator: valid strobe five edges after the edge that sees int_start.
    always @(posedge clk100 or posedge reset) begin
        if (reset) begin
            mcnt   <= 4'd0;
            mvalid <= 1'b0;
        end else begin
            mvalid <= 1'b0;
            if (int_start) begin
                mcnt <= 4'd5;
            end else if (mcnt != 4'd0) begin
                mcnt <= mcnt - 4'd1;
                if (mcnt == 4'd1 && model_en) mvalid <= 1'b1;
            end
        end
    end

    assign int_iq_valid  = mvalid | man_valid;
    assign int_i_val_tot = i_tab[res_idx[1:0]];
    assign int_q_val_tot = q_tab[res_idx[1:0]];

    task automatic start_run(input logic [7:0] n, input logic [7:0] d,
                             input logic [10:0] len, input logic [IQ_W-1:0] thr);
        @(negedge clk100);
        cfg_num_shots     = n;
        cfg_delay         = d;
        cfg_sample_length = len;
        cfg_threshold     = thr;
        cmd_start         = 1'b1;
        @(negedge clk100);
        cmd_start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk100);
        checks++;
        if ({int_start, res_valid, busy, done, error, res_excited} !== 6'b0)
            $display("FAIL reset_flags got %b want 000000",
                     {int_start, res_valid, busy, done, error, res_excited});
        else passes++;
        checks++;
        if (res_i !== '0 || res_q !== '0)
            $display("FAIL reset_iq got %0h/%0h want 0/0", res_i, res_q);
        else passes++;
        checks++;
        if (res_idx !== 8'd0 || excited_count !== 8'd0 || int_sample_length !== 11'd0)
            $display("FAIL reset_counts got idx=%0d cnt=%0d len=%0d want 0",
                     res_idx, excited_count, int_sample_length);
        else passes++;
        reset = 1'b0;
        repeat (2) @(negedge clk100);
    endtask

    task automatic test_three_shots;
        int t [3];
        int ns = 0;
        int nh = 0;
        int nd = 0;
        logic exp_exc [3];
        exp_exc[0] = 1'b0; exp_exc[1] = 1'b1; exp_exc[2] = 1'b0;
        i_tab[0] = 35'sd5;  i_tab[1] = 35'sd11; i_tab[2] = 35'sd10;
        q_tab[0] = -35'sd1; q_tab[1] = -35'sd2; q_tab[2] = -35'sd3;
        model_en  = 1'b1;
        res_ready = 1'b1;
        start_run(8'd3, 8'd2, 11'd3, 35'sd10);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk100);
            if (int_start) begin
                if (ns < 3) t[ns] = k;
                ns++;
            end
            if (res_valid && res_ready) begin
                checks++;
                if (nh > 2 || res_idx !== 8'(nh) || res_excited !== exp_exc[nh]
                    || res_i !== i_tab[nh] || res_q !== q_tab[nh])
                    $display("FAIL shot_result n=%0d got idx=%0d exc=%b i=%0d",
                             nh, res_idx, res_excited, $signed(res_i));
                else passes++;
                nh++;
            end
            if (done) nd++;
            if (k == 4) begin
                cfg_num_shots     = 8'd7;
                cfg_delay         = 8'd50;
                cfg_sample_length = 11'd99;
                cfg_threshold     = '0;
                cmd_start         = 1'b1;
            end
            if (k == 5) cmd_start = 1'b0;
            if (k == 15) begin
                checks++;
                if (int_sample_length !== 11'd3)
                    $display("FAIL latched_len got %0d want 3", int_sample_length);
                else passes++;
            end
        end
        checks++;
        if (ns != 3) $display("FAIL start_count got %0d want 3", ns);
        else passes++;
        checks++;
        if (ns == 3 && (t[1] - t[0] != 10 || t[2] - t[1] != 10))
            $display("FAIL start_spacing got %0d,%0d want 10,10", t[1] - t[0], t[2] - t[1]);
        else if (ns != 3) $display("FAIL start_spacing got n=%0d want 3 pulses", ns);
        else passes++;
        checks++;
        if (nh != 3) $display("FAIL handshakes got %0d want 3", nh);
        else passes++;
        checks++;
        if (nd != 1) $display("FAIL done_pulses got %0d want 1", nd);
        else passes++;
        checks++;
        if (excited_count !== 8'd1) $display("FAIL excited_count got %0d want 1", excited_count);
        else passes++;
        checks++;
        if (busy !== 1'b0 || error !== 1'b0)
            $display("FAIL end_status got busy=%b err=%b want 0/0", busy, error);
        else passes++;
    endtask

    task automatic test_backpressure;
        int found = 0;
        i_tab[0]  = -35'sd3;
        q_tab[0]  = 35'sd77;
        model_en  = 1'b1;
        res_ready = 1'b0;
        start_run(8'd1, 8'd0, 11'd3, -35'sd4);
        @(negedge clk100);
        checks++;
        if (int_start !== 1'b1) $display("FAIL delay0_start got %b want 1", int_start);
        else passes++;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk100);
            if (res_valid) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (found == 0) $display("FAIL bp_wait got timeout want res_valid");
        else passes++;
        for (int j = 0; j < 7; j++) begin
            if (j > 0) @(negedge clk100);
            checks++;
            if (res_valid !== 1'b1 || int_start !== 1'b0 || res_i !== i_tab[0]
                || res_q !== q_tab[0] || res_idx !== 8'd0 || res_excited !== 1'b1)
                $display("FAIL bp_hold j=%0d got v=%b s=%b i=%0d exc=%b want 1 0 -3 1",
                         j, res_valid, int_start, $signed(res_i), res_excited);
            else passes++;
        end
        res_ready = 1'b1;
        @(negedge clk100);
        checks++;
        if (res_valid !== 1'b0 || done !== 1'b1 || excited_count !== 8'd1)
            $display("FAIL bp_release got v=%b done=%b cnt=%0d want 0 1 1",
                     res_valid, done, excited_count);
        else passes++;
        @(negedge clk100);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL bp_idle got done=%b busy=%b want 0 0", done, busy);
        else passes++;
    endtask

    task automatic test_timeout;
        int en = 0;
        int nd = 0;
        model_en  = 1'b0;
        res_ready = 1'b1;
        start_run(8'd1, 8'd0, 11'd3, '0);
        @(negedge clk100);
        checks++;
        if (int_start !== 1'b1) $display("FAIL to_start got %b want 1", int_start);
        else passes++;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk100);
            if (done) nd++;
            if (n == 19) begin
                checks++;
                if (busy !== 1'b1 || error !== 1'b0)
                    $display("FAIL to_wait19 got busy=%b err=%b want 1 0", busy, error);
                else passes++;
            end
            if (error) begin
                en = n;
                break;
            end
        end
        checks++;
        if (en != 20) $display("FAIL to_cycle got %0d want 20", en);
        else passes++;
        checks++;
        if (busy !== 1'b0 || nd != 0)
            $display("FAIL to_idle got busy=%b dones=%0d want 0 0", busy, nd);
        else passes++;
        repeat (3) @(negedge clk100);
        checks++;
        if (error !== 1'b1) $display("FAIL to_sticky got %b want 1", error);
        else passes++;
    endtask

    task automatic test_abort;
        int found = 0;
        int bad = 0;
        model_en = 1'b0;
        start_run(8'd2, 8'd1, 11'd3, '0);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1)
            $display("FAIL ab_clear got err=%b busy=%b want 0 1", error, busy);
        else passes++;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk100);
            if (int_start) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (found == 0) $display("FAIL ab_wait got timeout want int_start");
        else passes++;
        repeat (2) @(negedge clk100);
        cmd_abort = 1'b1;
        man_valid = 1'b1;
        @(negedge clk100);
        cmd_abort = 1'b0;
        man_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || error !== 1'b0)
            $display("FAIL ab_idle got busy=%b v=%b err=%b want 0 0 0", busy, res_valid, error);
        else passes++;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk100);
            if (res_valid || done || int_start || busy) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL ab_quiet got %0d active cycles want 0", bad);
        else passes++;
    endtask

    task automatic test_zero_shots;
        int bad = 0;
        start_run(8'd0, 8'd5, 11'd3, '0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || int_start !== 1'b0)
            $display("FAIL z_done got done=%b busy=%b s=%b want 1 1 0", done, busy, int_start);
        else passes++;
        @(negedge clk100);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL z_idle got done=%b busy=%b want 0 0", done, busy);
        else passes++;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk100);
            if (int_start || done) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL z_quiet got %0d pulses want 0", bad);
        else passes++;
    endtask

    task automatic test_async_reset;
        int bad = 0;
        model_en  = 1'b1;
        res_ready = 1'b1;
        start_run(8'd2, 8'd5, 11'd3, '0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || int_sample_length !== 11'd0)
            $display("FAIL ar_now got busy=%b len=%0d want 0 0", busy, int_sample_length);
        else passes++;
        @(negedge clk100);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk100);
            if (int_start || done || res_valid || busy) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL ar_quiet got %0d active cycles want 0", bad);
        else passes++;
    endtask

    initial begin
        reset             = 1'b1;
        cmd_start         = 1'b0;
        cmd_abort         = 1'b0;
        cfg_num_shots     = '0;
        cfg_delay         = '0;
        cfg_sample_length = '0;
        cfg_threshold     = '0;
        res_ready         = 1'b0;
        model_en          = 1'b0;
        man_valid         = 1'b0;
        for (int i = 0; i < 4; i++) begin
            i_tab[i] = '0;
            q_tab[i] = '0;
        end
        test_reset();
        test_three_shots();
        test_backpressure();
        test_timeout();
        test_abort();
        test_zero_shots();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
